// File: rtl/debug_snapshot_tx.sv
// Debug readback engine: steps the system LED mux through sources 1..6, captures PC and
// LED words, then streams them as an 8N1 UART frame (A5, W0..W6 MSB first, XOR checksum).
module debug_snapshot_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SETTLE       = 2
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        snap_req,
    input  logic [31:0] out_PC,
    input  logic [31:0] SYS_leds,
    output logic [3:0]  out_sel,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    // state      | meaning
    // IDLE       | waiting for snap_req
    // CAPTURE    | holding out_sel = 1..6 for SETTLE cycles each, latching SYS_leds
    // SEND_START | start bit of the current byte
    // SEND_DATA  | eight data bits, LSB first
    // SEND_STOP  | stop bit, then next byte or DONE
    // DONE       | one-cycle done pulse, busy already low
    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SEND_START,
        SEND_DATA,
        SEND_STOP,
        DONE
    } state_t;

    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [4:0]  LAST_BYTE   = 5'd29;

    state_t      state, state_nxt;
    logic [31:0] words [0:6];
    logic [15:0] tmr, tmr_nxt;
    logic [2:0]  sel_k, sel_k_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [4:0]  byte_idx, byte_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  csum, csum_nxt;
    logic [3:0]  out_sel_nxt;
    logic        tx_nxt, busy_nxt, done_nxt;
    logic        pc_we, leds_we, load_en;
    logic [4:0]  load_idx, pay_idx;
    logic [7:0]  load_byte;
    logic [255:0] padded;

    // Byte about to be loaded: header, payload byte (load_idx-1), or the accumulated checksum.
    always_comb begin
        load_idx = (state == SEND_STOP) ? byte_idx + 5'd1 : 5'd0;
        pay_idx  = load_idx - 5'd1;
        padded   = {words[0], words[1], words[2], words[3], words[4], words[5], words[6], 32'h0};
        case (load_idx)
            5'd0:      load_byte = 8'hA5;
            LAST_BYTE: load_byte = csum;
            default:   load_byte = padded[{5'd31 - pay_idx, 3'b000} +: 8];
        endcase
    end

    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr;
        sel_k_nxt    = sel_k;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        shreg_nxt    = shreg;
        csum_nxt     = csum;
        out_sel_nxt  = out_sel;
        tx_nxt       = tx;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        pc_we        = 1'b0;
        leds_we      = 1'b0;
        load_en      = 1'b0;
        case (state)
            IDLE: begin
                if (snap_req) begin
                    pc_we       = 1'b1;
                    out_sel_nxt = 4'd1;
                    busy_nxt    = 1'b1;
                    sel_k_nxt   = 3'd1;
                    tmr_nxt     = SETTLE_LAST;
                    csum_nxt    = 8'h00;
                    state_nxt   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (tmr == 16'd0) begin
                    leds_we = 1'b1;
                    if (sel_k == 3'd6) begin
                        out_sel_nxt  = 4'd0;
                        byte_idx_nxt = 5'd0;
                        load_en      = 1'b1;
                        tx_nxt       = 1'b0;
                        tmr_nxt      = BIT_LAST;
                        state_nxt    = SEND_START;
                    end else begin
                        sel_k_nxt   = sel_k + 3'd1;
                        out_sel_nxt = {1'b0, sel_k + 3'd1};
                        tmr_nxt     = SETTLE_LAST;
                    end
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            SEND_START: begin
                if (tmr == 16'd0) begin
                    tx_nxt      = shreg[0];
                    bit_idx_nxt = 3'd0;
                    tmr_nxt     = BIT_LAST;
                    state_nxt   = SEND_DATA;
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            SEND_DATA: begin
                if (tmr == 16'd0) begin
                    tmr_nxt = BIT_LAST;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = SEND_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shreg_nxt   = shreg >> 1;
                        tx_nxt      = shreg[1];
                    end
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            SEND_STOP: begin
                if (tmr == 16'd0) begin
                    if (byte_idx == LAST_BYTE) begin
                        tx_nxt    = 1'b1;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        byte_idx_nxt = byte_idx + 5'd1;
                        load_en      = 1'b1;
                        tx_nxt       = 1'b0;
                        tmr_nxt      = BIT_LAST;
                        state_nxt    = SEND_START;
                    end
                end else begin
                    tmr_nxt = tmr - 16'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Checksum covers payload bytes only, folded in as each one is loaded.
        if (load_en) begin
            shreg_nxt = load_byte;
            if (load_idx != 5'd0 && load_idx != LAST_BYTE) begin
                csum_nxt = csum ^ load_byte;
            end
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state    <= IDLE;
            tmr      <= 16'd0;
            sel_k    <= 3'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 5'd0;
            shreg    <= 8'h00;
            csum     <= 8'h00;
            out_sel  <= 4'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            sel_k    <= sel_k_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            shreg    <= shreg_nxt;
            csum     <= csum_nxt;
            out_sel  <= out_sel_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            for (int i = 0; i < 7; i++) begin
                words[i] <= 32'h0;
            end
        end else begin
            if (pc_we) begin
                words[0] <= out_PC;
            end
            for (int i = 1; i < 7; i++) begin
                if (leds_we && sel_k == 3'(i)) begin
                    words[i] <= SYS_leds;
                end
            end
        end
    end

endmodule
